// File: rtl/rv32i_dmem_dump_reader_pkg.sv
// Shared types for the end-of-test data-memory dump reader.
package rv32i_dmem_dump_reader_pkg;

    localparam int unsigned DumpAddrW = 32;

    typedef enum logic [1:0] {
        EotNone    = 2'd0,
        EotEbreak  = 2'd1,
        EotEcall   = 2'd2,
        EotIllegal = 2'd3
    } t_eot_reason;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } t_dump_state;

    typedef struct packed {
        logic [DumpAddrW-1:0] addr;
        logic [31:0]          data;
        logic                 last;
    } t_dump_entry;

endpackage

// File: rtl/rv32i_dmem_dump_reader_if.sv
// Valid/ready stream carrying {addr, data, last} dump words to the consumer.
interface rv32i_dmem_dump_reader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [31:0]       dump_data;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_addr,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/rv32i_dmem_dump_reader_skid_buf.sv
// Two-entry FIFO of dump entries; push and pop may happen in the same cycle.
module rv32i_dmem_dump_reader_skid_buf
    import rv32i_dmem_dump_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  t_dump_entry push_entry,
    input  logic        pop,
    output t_dump_entry head,
    output logic        full,
    output logic        empty,
    output logic [1:0]  count
);
    t_dump_entry mem_q [2];
    t_dump_entry mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        // A full buffer still accepts a push when the head leaves this cycle.
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/rv32i_dmem_dump_reader.sv
// After an end-of-test trigger, reads D_MEM word by word and streams {addr,data,last}
// to the consumer through a two-entry buffer.
module rv32i_dmem_dump_reader
    import rv32i_dmem_dump_reader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DumpAddrW,
    parameter logic [ADDR_W-1:0] D_MEM_LSB = 'h1_0000,
    parameter logic [ADDR_W-1:0] D_MEM_MSB = 'h1_FFFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ebreak_was_called,
    input  logic                      ecall_was_called,
    input  logic                      illegal_instruction,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [31:0]               mem_rd_data,
    rv32i_dmem_dump_reader_if.master  dump_if,
    output t_eot_reason               eot_reason,
    output logic                      dump_done
);
    localparam logic [ADDR_W-1:0] RangeBytes = D_MEM_MSB - D_MEM_LSB + ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LastAddr   = D_MEM_MSB - ADDR_W'(3);

    if (ADDR_W != DumpAddrW) begin : g_bad_width
        $error("rv32i_dmem_dump_reader: ADDR_W must equal the dump entry address width");
    end
    if (D_MEM_LSB[1:0] != 2'b00 || RangeBytes[1:0] != 2'b00) begin : g_bad_range
        $error("rv32i_dmem_dump_reader: D_MEM range must be word aligned and sized");
    end

    t_dump_state       state_q, state_d;
    t_eot_reason       reason_q, reason_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_last_q, pend_last_d;

    t_dump_entry       push_entry;
    t_dump_entry       head;
    logic              buf_full, buf_empty;
    logic [1:0]        buf_count;
    logic              pop;
    logic              has_room;

    assign pop = !buf_empty && dump_if.dump_ready;

    // Slots left once this cycle's pop and the read already in flight are accounted for.
    assign has_room = (({1'b0, buf_count} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop}))
                      && (!buf_full || pop);

    assign push_entry = '{addr: pend_addr_q, data: mem_rd_data, last: pend_last_q};

    rv32i_dmem_dump_reader_skid_buf u_skid_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pend_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    always_comb begin
        state_d     = state_q;
        reason_d    = reason_q;
        addr_d      = addr_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_last_d = pend_last_q;
        mem_rd_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (illegal_instruction) begin
                    reason_d = EotIllegal;
                    state_d  = StRead;
                end else if (ecall_was_called) begin
                    reason_d = EotEcall;
                    state_d  = StRead;
                end else if (ebreak_was_called) begin
                    reason_d = EotEbreak;
                    state_d  = StRead;
                end
            end
            StRead: begin
                if (has_room) begin
                    mem_rd_en   = 1'b1;
                    pend_d      = 1'b1;
                    pend_addr_d = addr_q;
                    pend_last_d = (addr_q == LastAddr);
                    addr_d      = addr_q + ADDR_W'(4);
                    if (addr_q == LastAddr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && head.last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            reason_q    <= EotNone;
            addr_q      <= D_MEM_LSB;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reason_q    <= reason_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_last_q <= pend_last_d;
        end
    end

    assign mem_rd_addr        = mem_rd_en ? addr_q : '0;
    assign dump_if.dump_valid = !buf_empty;
    assign dump_if.dump_addr  = buf_empty ? '0 : head.addr;
    assign dump_if.dump_data  = buf_empty ? '0 : head.data;
    assign dump_if.dump_last  = !buf_empty && head.last;
    assign eot_reason         = reason_q;
    assign dump_done          = (state_q == StDone);

endmodule

// File: tb/tb_rv32i_dmem_dump_reader.sv
// Directed bench for the D_MEM dump reader: full-range instance plus an 8-byte instance.
module tb_rv32i_dmem_dump_reader;
    import rv32i_dmem_dump_reader_pkg::*;

    localparam logic [31:0] Lsb   = 32'h0001_0000;
    localparam logic [31:0] Msb   = 32'h0001_FFFF;
    localparam int          Words = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ebreak = 1'b0, ecall = 1'b0, illegal = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = 32'h0;
    t_eot_reason eot_reason;
    logic        dump_done;
    rv32i_dmem_dump_reader_if #(.ADDR_W(32)) dif ();

    logic        s_ebreak = 1'b0, s_ecall = 1'b0, s_illegal = 1'b0;
    logic        s_mem_rd_en;
    logic [31:0] s_mem_rd_addr;
    logic [31:0] s_mem_rd_data = 32'h0;
    t_eot_reason s_eot_reason;
    logic        s_dump_done;
    rv32i_dmem_dump_reader_if #(.ADDR_W(32)) sif ();

    rv32i_dmem_dump_reader #(.ADDR_W(32), .D_MEM_LSB(Lsb), .D_MEM_MSB(Msb)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ebreak_was_called   (ebreak),
        .ecall_was_called    (ecall),
        .illegal_instruction (illegal),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_data         (mem_rd_data),
        .dump_if             (dif),
        .eot_reason          (eot_reason),
        .dump_done           (dump_done)
    );

    rv32i_dmem_dump_reader #(.ADDR_W(32), .D_MEM_LSB(32'h100), .D_MEM_MSB(32'h107)) u_small (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ebreak_was_called   (s_ebreak),
        .ecall_was_called    (s_ecall),
        .illegal_instruction (s_illegal),
        .mem_rd_en           (s_mem_rd_en),
        .mem_rd_addr         (s_mem_rd_addr),
        .mem_rd_data         (s_mem_rd_data),
        .dump_if             (sif),
        .eot_reason          (s_eot_reason),
        .dump_done           (s_dump_done)
    );

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int s_rd_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0001_0000) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        mem_rd_data   <= mem_rd_en ? mem_word(mem_rd_addr) : 32'h0;
        s_mem_rd_data <= s_mem_rd_en ? mem_word(s_mem_rd_addr) : 32'h0;
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (s_mem_rd_en) s_rd_cnt <= s_rd_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        dif.dump_ready = 1'b0;
        sif.dump_ready = 1'b0;
        do_reset();
        checks++;
        if ({mem_rd_en, mem_rd_addr, dif.dump_valid, dif.dump_addr, dif.dump_data,
             dif.dump_last, eot_reason, dump_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%0b a=%h v=%0b eot=%0d done=%0b want all 0",
                     mem_rd_en, mem_rd_addr, dif.dump_valid, eot_reason, dump_done);
        end
        checks++;
        if (dut.state_q !== StIdle) begin
            errors++;
            $display("FAIL reset_state got %0d want %0d", dut.state_q, StIdle);
        end
    endtask

    task automatic test_basic();
        int          beats = 0;
        int          start_rd;
        logic [31:0] exp_addr = Lsb;
        bit          stop = 1'b0;
        dif.dump_ready = 1'b1;
        start_rd = rd_cnt;
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        checks++;
        if ({mem_rd_en, mem_rd_addr} !== {1'b1, Lsb}) begin
            errors++;
            $display("FAIL basic_first_read got en=%0b a=%h want en=1 a=%h",
                     mem_rd_en, mem_rd_addr, Lsb);
        end
        checks++;
        if (eot_reason !== EotEbreak) begin
            errors++;
            $display("FAIL basic_eot_early got %0d want 1", eot_reason);
        end
        @(negedge clk);
        checks++;
        if (dif.dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_early got %0b want 0", dif.dump_valid);
        end
        @(negedge clk);
        checks++;
        if ({dif.dump_valid, dif.dump_addr, dif.dump_data} !== {1'b1, 32'h10000, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_first_beat got v=%0b a=%h d=%h want v=1 a=00010000 d=deadbeef",
                     dif.dump_valid, dif.dump_addr, dif.dump_data);
        end
        for (int cyc = 0; cyc < Words + 50 && !stop; cyc++) begin
            if (cyc > 0) @(negedge clk);
            checks++;
            if (dif.dump_valid !== 1'b1 || dif.dump_addr !== exp_addr ||
                dif.dump_data !== mem_word(exp_addr) ||
                dif.dump_last !== (exp_addr == Msb - 32'd3)) begin
                errors++;
                $display("FAIL basic_beat got v=%0b a=%h d=%h l=%0b want v=1 a=%h d=%h l=%0b",
                         dif.dump_valid, dif.dump_addr, dif.dump_data, dif.dump_last,
                         exp_addr, mem_word(exp_addr), (exp_addr == Msb - 32'd3));
                stop = 1'b1;
            end else begin
                beats++;
                if (dif.dump_last) stop = 1'b1;
                exp_addr += 32'd4;
            end
        end
        @(negedge clk);
        checks++;
        if (beats !== Words) begin
            errors++;
            $display("FAIL basic_beat_count got %0d want %0d", beats, Words);
        end
        checks++;
        if ({dump_done, dif.dump_valid} !== 2'b10) begin
            errors++;
            $display("FAIL basic_done got done=%0b v=%0b want done=1 v=0", dump_done, dif.dump_valid);
        end
        checks++;
        if (rd_cnt - start_rd !== Words) begin
            errors++;
            $display("FAIL basic_read_count got %0d want %0d", rd_cnt - start_rd, Words);
        end
        checks++;
        if (eot_reason !== EotEbreak) begin
            errors++;
            $display("FAIL basic_eot got %0d want 1", eot_reason);
        end
    endtask

    task automatic test_post_done();
        int start_rd = rd_cnt;
        for (int t = 0; t < 3; t++) begin
            ebreak  = (t == 0);
            ecall   = (t == 1);
            illegal = (t == 2);
            @(negedge clk);
            ebreak  = 1'b0;
            ecall   = 1'b0;
            illegal = 1'b0;
            @(negedge clk);
            checks++;
            if ({dif.dump_valid, dump_done, eot_reason} !== {1'b0, 1'b1, EotEbreak}) begin
                errors++;
                $display("FAIL post_done_trig%0d got v=%0b done=%0b eot=%0d want v=0 done=1 eot=1",
                         t, dif.dump_valid, dump_done, eot_reason);
            end
        end
        checks++;
        if (rd_cnt - start_rd !== 0) begin
            errors++;
            $display("FAIL post_done_reads got %0d want 0", rd_cnt - start_rd);
        end
    endtask

    task automatic test_priority();
        int          beats = 0;
        logic [31:0] exp_addr = Lsb;
        bit          stop = 1'b0;
        do_reset();
        dif.dump_ready = 1'b1;
        ecall   = 1'b1;
        illegal = 1'b1;
        @(negedge clk);
        ecall   = 1'b0;
        illegal = 1'b0;
        checks++;
        if (eot_reason !== EotIllegal) begin
            errors++;
            $display("FAIL prio_eot got %0d want 3", eot_reason);
        end
        for (int cyc = 0; cyc < 200 && !stop; cyc++) begin
            ebreak = (cyc == 10);
            if (dif.dump_valid) begin
                checks++;
                if (dif.dump_addr !== exp_addr || dif.dump_data !== mem_word(exp_addr)) begin
                    errors++;
                    $display("FAIL prio_beat got a=%h d=%h want a=%h d=%h",
                             dif.dump_addr, dif.dump_data, exp_addr, mem_word(exp_addr));
                    stop = 1'b1;
                end else begin
                    beats++;
                    exp_addr += 32'd4;
                    if (beats == 100) stop = 1'b1;
                end
            end
            if (!stop) @(negedge clk);
        end
        ebreak = 1'b0;
        checks++;
        if (beats !== 100) begin
            errors++;
            $display("FAIL prio_beat_count got %0d want 100", beats);
        end
        checks++;
        if (eot_reason !== EotIllegal) begin
            errors++;
            $display("FAIL prio_eot_hold got %0d want 3", eot_reason);
        end
    endtask

    task automatic test_reset_mid_dump();
        do_reset();
        checks++;
        if ({mem_rd_en, mem_rd_addr, dif.dump_valid, dif.dump_addr, dif.dump_data,
             dif.dump_last, eot_reason, dump_done} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got en=%0b a=%h v=%0b da=%h eot=%0d want all 0",
                     mem_rd_en, mem_rd_addr, dif.dump_valid, dif.dump_addr, eot_reason);
        end
        checks++;
        if (dut.state_q !== StIdle) begin
            errors++;
            $display("FAIL midreset_state got %0d want %0d", dut.state_q, StIdle);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_rd_en, dif.dump_valid} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_quiet got en=%0b v=%0b want 0 0", mem_rd_en, dif.dump_valid);
        end
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        checks++;
        if ({mem_rd_en, mem_rd_addr} !== {1'b1, Lsb}) begin
            errors++;
            $display("FAIL midreset_restart_read got en=%0b a=%h want en=1 a=%h",
                     mem_rd_en, mem_rd_addr, Lsb);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({dif.dump_valid, dif.dump_addr, eot_reason} !== {1'b1, Lsb, EotEbreak}) begin
            errors++;
            $display("FAIL midreset_restart_beat got v=%0b a=%h eot=%0d want v=1 a=%h eot=1",
                     dif.dump_valid, dif.dump_addr, eot_reason, Lsb);
        end
    endtask

    task automatic test_backpressure();
        int          beats = 0;
        logic [31:0] exp_addr = Lsb;
        logic        held = 1'b0;
        logic [64:0] hold_v = '0;
        bit          stop = 1'b0;
        do_reset();
        void'($urandom(7));
        dif.dump_ready = 1'b0;
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        for (int cyc = 0; cyc < 50000 && !stop; cyc++) begin
            if (held) begin
                checks++;
                if (dif.dump_valid !== 1'b1 ||
                    {dif.dump_addr, dif.dump_data, dif.dump_last} !== hold_v) begin
                    errors++;
                    $display("FAIL bp_stable got v=%0b a=%h d=%h want v=1 a=%h d=%h",
                             dif.dump_valid, dif.dump_addr, dif.dump_data,
                             hold_v[64:33], hold_v[32:1]);
                    stop = 1'b1;
                end
                held = 1'b0;
            end
            dif.dump_ready = 1'($urandom_range(0, 1));
            if (dif.dump_valid && !stop) begin
                if (dif.dump_ready) begin
                    checks++;
                    if (dif.dump_addr !== exp_addr || dif.dump_data !== mem_word(exp_addr) ||
                        dif.dump_last !== (exp_addr == Msb - 32'd3)) begin
                        errors++;
                        $display("FAIL bp_beat got a=%h d=%h l=%0b want a=%h d=%h l=%0b",
                                 dif.dump_addr, dif.dump_data, dif.dump_last, exp_addr,
                                 mem_word(exp_addr), (exp_addr == Msb - 32'd3));
                        stop = 1'b1;
                    end else begin
                        beats++;
                        if (dif.dump_last) stop = 1'b1;
                        exp_addr += 32'd4;
                    end
                end else begin
                    held   = 1'b1;
                    hold_v = {dif.dump_addr, dif.dump_data, dif.dump_last};
                end
            end
            @(negedge clk);
        end
        dif.dump_ready = 1'b1;
        checks++;
        if (beats !== Words) begin
            errors++;
            $display("FAIL bp_beat_count got %0d want %0d", beats, Words);
        end
        checks++;
        if (dump_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done got %0b want 1", dump_done);
        end
    endtask

    task automatic test_small_range();
        int start_rd;
        do_reset();
        sif.dump_ready = 1'b0;
        start_rd = s_rd_cnt;
        s_ebreak = 1'b1;
        @(negedge clk);
        s_ebreak = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if ({sif.dump_valid, sif.dump_addr, sif.dump_data, sif.dump_last} !==
                    {1'b1, 32'h100, mem_word(32'h100), 1'b0}) begin
                    errors++;
                    $display("FAIL small_hold c=%0d got v=%0b a=%h l=%0b want v=1 a=100 l=0",
                             c, sif.dump_valid, sif.dump_addr, sif.dump_last);
                end
            end
        end
        checks++;
        if (s_rd_cnt - start_rd !== 2) begin
            errors++;
            $display("FAIL small_reads got %0d want 2", s_rd_cnt - start_rd);
        end
        sif.dump_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({sif.dump_valid, sif.dump_addr, sif.dump_data, sif.dump_last} !==
            {1'b1, 32'h104, mem_word(32'h104), 1'b1}) begin
            errors++;
            $display("FAIL small_last got v=%0b a=%h l=%0b want v=1 a=104 l=1",
                     sif.dump_valid, sif.dump_addr, sif.dump_last);
        end
        @(negedge clk);
        checks++;
        if ({s_dump_done, sif.dump_valid, s_eot_reason} !== {1'b1, 1'b0, EotEbreak}) begin
            errors++;
            $display("FAIL small_done got done=%0b v=%0b eot=%0d want done=1 v=0 eot=1",
                     s_dump_done, sif.dump_valid, s_eot_reason);
        end
        checks++;
        if (s_rd_cnt - start_rd !== 2) begin
            errors++;
            $display("FAIL small_reads_final got %0d want 2", s_rd_cnt - start_rd);
        end
    endtask

    initial begin
        dif.dump_ready = 1'b0;
        sif.dump_ready = 1'b0;
        test_reset();
        test_basic();
        test_post_done();
        test_priority();
        test_reset_mid_dump();
        test_backpressure();
        test_small_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
